// File: rtl/keypad_entry_display.sv
// keypad_entry_display: debounces decoded keypad presses, shifts each accepted
// hex key into a 4-digit entry register and scans that register onto a
// 4-digit common-anode 7-segment display.
// Optional feature macro: KEYPAD_LEADING_BLANK_EN (blank digit positions that
// have not been entered yet since reset or clear).
module keypad_entry_display #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REFRESH_CYCLES  = 100000
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic [3:0]  key_code,
  input  logic        key_valid,
  input  logic        clear,
  output logic        key_strobe,
  output logic [15:0] digits,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int RF_W = $clog2(REFRESH_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RF_W-1:0] RF_LAST = RF_W'(REFRESH_CYCLES - 1);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  logic [1:0]      state;
  logic [DB_W-1:0] db_cnt;
  logic [3:0]      code_q;
  logic            accept;
  logic [2:0]      count;
  logic [RF_W-1:0] rf_cnt;
  logic [1:0]      sel;
  logic [3:0]      nibble;
  logic [3:0]      an_next;
  logic [6:0]      seg_next;

  // A press is accepted on the cycle the key has been stable for the full window
  assign accept = (state == PRESS_WAIT) && key_valid && (key_code == code_q) &&
                  (db_cnt == DB_LAST);

  // Debounce FSM: one strobe per stable press, release must also be stable
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state      <= IDLE;
      db_cnt     <= '0;
      code_q     <= '0;
      key_strobe <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (key_valid) begin
            code_q <= key_code;
            db_cnt <= '0;
            state  <= PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (!key_valid || (key_code != code_q)) begin
            state <= IDLE;
          end else if (db_cnt == DB_LAST) begin
            state      <= HELD;
            key_strobe <= 1'b1;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        HELD: begin
          if (!key_valid) begin
            state  <= RELEASE_WAIT;
            db_cnt <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (key_valid) begin
            state <= HELD;
          end else if (db_cnt == DB_LAST) begin
            state <= IDLE;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Entry register: clear wins over a same-cycle shift; count saturates at 4
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      digits <= 16'h0000;
      count  <= 3'd0;
    end else if (clear) begin
      digits <= 16'h0000;
      count  <= 3'd0;
    end else if (accept) begin
      digits <= {digits[11:0], code_q};
      if (count != 3'd4) begin
        count <= count + 3'd1;
      end
    end
  end

  // Decode the digit for the current scan slot into anode and cathode patterns
  always_comb begin
    nibble  = digits[{sel, 2'b00} +: 4];
    an_next = 4'(~(4'b0001 << sel));
    case (nibble)
      4'h0: seg_next = 7'b1000000;
      4'h1: seg_next = 7'b1111001;
      4'h2: seg_next = 7'b0100100;
      4'h3: seg_next = 7'b0110000;
      4'h4: seg_next = 7'b0011001;
      4'h5: seg_next = 7'b0010010;
      4'h6: seg_next = 7'b0000010;
      4'h7: seg_next = 7'b1111000;
      4'h8: seg_next = 7'b0000000;
      4'h9: seg_next = 7'b0010000;
      4'hA: seg_next = 7'b0001000;
      4'hB: seg_next = 7'b0000011;
      4'hC: seg_next = 7'b1000110;
      4'hD: seg_next = 7'b0100001;
      4'hE: seg_next = 7'b0000110;
      default: seg_next = 7'b0001110;
    endcase
`ifdef KEYPAD_LEADING_BLANK_EN
    if ({1'b0, sel} >= count) begin
      an_next  = 4'b1111;
      seg_next = 7'b1111111;
    end
`endif
  end

  // Display scan: outputs only change on refresh wrap so digits never glitch
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      rf_cnt <= '0;
      sel    <= 2'd0;
      an     <= 4'b1111;
      seg    <= 7'b1111111;
    end else if (rf_cnt == RF_LAST) begin
      rf_cnt <= '0;
      an     <= an_next;
      seg    <= seg_next;
      sel    <= sel + 2'd1;
    end else begin
      rf_cnt <= rf_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_keypad_entry_display.sv
// tb_keypad_entry_display: directed bench for keypad_entry_display with
// DEBOUNCE_CYCLES=4 and REFRESH_CYCLES=8. Strobe expectations go through a
// scoreboard queue; a negedge monitor pops and checks them on every strobe.
module tb_keypad_entry_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        clear;
  logic        key_strobe;
  logic [15:0] digits;
  logic [3:0]  an;
  logic [6:0]  seg;

  typedef struct {
    int          cyc;
    logic [15:0] dig;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  keypad_entry_display #(
    .DEBOUNCE_CYCLES(4),
    .REFRESH_CYCLES (8)
  ) dut (
    .clk_100MHz(clk),
    .reset     (reset),
    .key_code  (key_code),
    .key_valid (key_valid),
    .clear     (clear),
    .key_strobe(key_strobe),
    .digits    (digits),
    .an        (an),
    .seg       (seg)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Posedge counter used to time-stamp strobes
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic logic [6:0] segOf(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Monitor: every strobe must match the oldest scoreboard entry
  always @(negedge clk) begin
    exp_t e;
    if (!reset && key_strobe) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_strobe: got strobe at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        checkOutput("strobe_cycle", cyc, e.cyc);
        checkOutput("digits_at_strobe", digits, e.dig);
      end
    end
  end

  // Drive inputs at a negedge and hold them for n negedges
  task automatic applyStimulus(input logic [3:0] code, input logic valid, input logic clr, input int n);
    key_code  = code;
    key_valid = valid;
    clear     = clr;
    repeat (n) @(negedge clk);
  endtask

  // Clean press: strobe expected on the 5th posedge after valid is driven
  task automatic pressKey(input logic [3:0] code, input logic [15:0] expDig);
    exp_t e;
    e.cyc = cyc + 5;
    e.dig = expDig;
    sb.push_back(e);
    applyStimulus(code, 1'b1, 1'b0, 6);
    applyStimulus(code, 1'b0, 1'b0, 6);
  endtask

  // Watch a full scan rotation and check each lit slot's cathodes
  task automatic checkScan(input logic [15:0] d, input int cnt);
    logic [3:0] prev;
    logic [3:0] seen;
    logic [3:0] want;
    int         k;
    prev = an;
    seen = 4'b0000;
`ifdef KEYPAD_LEADING_BLANK_EN
    want = 4'((1 << cnt) - 1);
`else
    want = 4'b1111;
    k = cnt;
`endif
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (an != prev) begin
        prev = an;
        if (an != 4'b1111) begin
          k = -1;
          for (int j = 0; j < 4; j++) begin
            if (an == 4'(~(4'b0001 << j))) k = j;
          end
          if (k >= 0) begin
            seen[k] = 1'b1;
            checkOutput($sformatf("scan_seg_slot%0d", k), seg, segOf(d[4*k +: 4]));
          end else begin
            checkOutput("scan_an_onehot", an, 4'b1111);
          end
        end
      end
    end
    checkOutput("scan_slots_lit", seen, want);
  endtask

  // Bound the whole run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    int lit;
    logic [15:0] exp4 [5];
    exp4[0] = 16'h0581; exp4[1] = 16'h5812; exp4[2] = 16'h8123;
    exp4[3] = 16'h1234; exp4[4] = 16'h2345;

    reset = 1'b1;
    key_code = 4'h0;
    key_valid = 1'b0;
    clear = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_an", an, 4'b1111);
    checkOutput("reset_seg", seg, 7'b1111111);
    checkOutput("reset_digits", digits, 16'h0000);
    checkOutput("reset_strobe", key_strobe, 1'b0);

    $display("[TB] test 1: first lit digit after reset");
    reset = 1'b0;
    lit = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (an != 4'b1111) begin
        lit = i;
        break;
      end
    end
`ifdef KEYPAD_LEADING_BLANK_EN
    checkOutput("dark_after_reset", lit, 0);
`else
    checkOutput("first_lit_latency", lit, 8);
    checkOutput("first_lit_an", an, 4'b1110);
    checkOutput("first_lit_seg", seg, 7'b1000000);
`endif

    $display("[TB] test 2: single press of 5");
    begin
      exp_t e;
      e.cyc = cyc + 5;
      e.dig = 16'h0005;
      sb.push_back(e);
    end
    applyStimulus(4'h5, 1'b1, 1'b0, 20);
    applyStimulus(4'h5, 1'b0, 1'b0, 10);
    checkOutput("digits_after_5", digits, 16'h0005);

    $display("[TB] test 3: short pulse and release gap");
    applyStimulus(4'h6, 1'b1, 1'b0, 2);
    applyStimulus(4'h6, 1'b0, 1'b0, 6);
    checkOutput("digits_after_pulse", digits, 16'h0005);
    begin
      exp_t e;
      e.cyc = cyc + 5;
      e.dig = 16'h0058;
      sb.push_back(e);
    end
    applyStimulus(4'h8, 1'b1, 1'b0, 10);
    applyStimulus(4'h8, 1'b0, 1'b0, 2);
    applyStimulus(4'h8, 1'b1, 1'b0, 10);
    applyStimulus(4'h8, 1'b0, 1'b0, 10);
    checkOutput("digits_after_gap", digits, 16'h0058);

    $display("[TB] test 4: presses 1..5 and scan");
    for (int i = 0; i < 5; i++) begin
      pressKey(4'(i + 1), exp4[i]);
    end
    checkOutput("digits_after_12345", digits, 16'h2345);
    checkScan(16'h2345, 4);

    $display("[TB] test 5: clear coincident with strobe");
    begin
      exp_t e;
      e.cyc = cyc + 5;
      e.dig = 16'h0000;
      sb.push_back(e);
    end
    applyStimulus(4'hA, 1'b1, 1'b0, 4);
    applyStimulus(4'hA, 1'b1, 1'b1, 1);
    applyStimulus(4'hA, 1'b1, 1'b0, 6);
    applyStimulus(4'hA, 1'b0, 1'b0, 8);
    checkOutput("digits_after_clear", digits, 16'h0000);
    pressKey(4'h7, 16'h0007);
    checkOutput("digits_after_7", digits, 16'h0007);

    $display("[TB] test 6: clear then press 9, scan");
    applyStimulus(4'h0, 1'b0, 1'b1, 1);
    applyStimulus(4'h0, 1'b0, 1'b0, 2);
    checkOutput("digits_after_clear2", digits, 16'h0000);
    pressKey(4'h9, 16'h0009);
    checkScan(16'h0009, 1);

    applyStimulus(4'h0, 1'b0, 1'b0, 4);
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
